adc_capture_ctrl: RTL

//  Parametrised successor of the single-shot ADC-to-RAM capture controller. It selects one of
//  CH_NUM ADC channels, decimates by a CSR factor and writes a programmable number of samples

---
 rtl/adc_capture_ctrl_if.sv | 24 ++
 rtl/adc_capture_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl_if.sv
// rtl/adc_capture_ctrl_if.sv - ADC sample stream in, capture RAM write port out
interface adc_capture_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int CH_NUM = 2,
   parameter int ADDR_W = 13
);
   logic [CH_NUM*DATA_W-1:0] adc_sample_in;
   logic                     adc_valid_in;
   logic                     adc_we_o;
   logic [ADDR_W-1:0]        adc_addr_o;
   logic [DATA_W-1:0]        adc_data_o;

   // Front-end / RAM side: drives samples, observes the write port
   modport master (
      output adc_sample_in, adc_valid_in,
      input  adc_we_o, adc_addr_o, adc_data_o
   );

   // Capture controller side
   modport slave (
      input  adc_sample_in, adc_valid_in,
      output adc_we_o, adc_addr_o, adc_data_o
   );
endinterface

// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - channel-select, decimate and store ADC samples into capture RAM
module adc_capture_ctrl #(
   parameter int DATA_W    = 32,
   parameter int CH_NUM    = 2,
   parameter int ADDR_W    = 13,
   parameter int BASE_ADDR = 'h400,
   parameter int DEPTH     = 4096,
   localparam int CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
   localparam int LEN_W    = $clog2(DEPTH) + 1
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   adc_capture_ctrl_if.slave   bus,
   input  logic                trig_i,
   input  logic                csr_start_i,
   input  logic                csr_abort_i,
   input  logic                csr_trig_mode_i,
   input  logic [CH_W-1:0]     csr_ch_sel_i,
   input  logic [7:0]          csr_decim_i,
   input  logic [LEN_W-1:0]    csr_len_i,
   output logic                csr_busy_o,
   output logic                csr_done_o,
   output logic [LEN_W-1:0]    csr_count_o
);

   if (BASE_ADDR + DEPTH > 2**ADDR_W) begin : g_bad_range
      $error("adc_capture_ctrl: BASE_ADDR + DEPTH exceeds RAM address space");
   end

   typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

   state_t              state, state_nxt;
   logic [CH_W-1:0]     ch_q;
   logic [7:0]          decim_q;
   logic [LEN_W-1:0]    len_q;
   logic [7:0]          dcnt;
   logic [LEN_W-1:0]    index;
   logic                done_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic [DATA_W-1:0]   sel_sample;
   logic                idle_like;
   logic                start_ok;
   logic                keep;
   logic                last;
   logic                trig_go;

   // Qualified control events shared by the FSM and the datapath
   always_comb begin
      idle_like = (state == IDLE) || (state == DONE);
      start_ok  = csr_start_i && !csr_abort_i && idle_like;
      trig_go   = (state == ARMED) && trig_i && !csr_abort_i;
      keep      = (state == RUN) && !csr_abort_i && bus.adc_valid_in && (dcnt == 8'd0);
      last      = keep && ((index + LEN_W'(1)) == len_q);
   end

   // Pick the latched channel out of the packed sample bus
   always_comb begin
      sel_sample = '0;
      for (int k = 0; k < CH_NUM; k++) begin
         if (ch_q == CH_W'(k)) sel_sample = bus.adc_sample_in[k*DATA_W +: DATA_W];
      end
   end

   // State register
   always_ff @(posedge sys_clk) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic; abort always has priority over start/trigger/completion
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (csr_abort_i)      state_nxt = IDLE;
            else if (csr_start_i) state_nxt = csr_trig_mode_i ? ARMED : RUN;
         end
         ARMED: begin
            if (csr_abort_i) state_nxt = IDLE;
            else if (trig_i) state_nxt = RUN;
         end
         RUN: begin
            if (csr_abort_i) state_nxt = IDLE;
            else if (last)   state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Config latch, decimation, write issue and completion tracking
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         ch_q    <= '0;
         decim_q <= '0;
         len_q   <= '0;
         dcnt    <= '0;
         index   <= '0;
         done_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         we_q <= keep;
         if (keep) begin
            addr_q <= ADDR_W'(BASE_ADDR) + ADDR_W'(index);
            data_q <= sel_sample;
            index  <= index + LEN_W'(1);
         end
         if (start_ok) begin
            ch_q    <= (32'(csr_ch_sel_i) >= CH_NUM) ? '0 : csr_ch_sel_i;
            decim_q <= csr_decim_i;
            len_q   <= (csr_len_i == '0 || 32'(csr_len_i) > DEPTH) ? LEN_W'(DEPTH) : csr_len_i;
            index   <= '0;
            done_q  <= 1'b0;
         end
         if (csr_abort_i && idle_like) done_q <= 1'b0;
         if (last) done_q <= 1'b1;
         // The keep counter restarts on every entry into RUN
         if ((start_ok && !csr_trig_mode_i) || trig_go)
            dcnt <= '0;
         else if (state == RUN && bus.adc_valid_in)
            dcnt <= (dcnt == decim_q) ? 8'd0 : dcnt + 8'd1;
      end
   end

   assign csr_busy_o     = (state == ARMED) || (state == RUN);
   assign csr_done_o     = done_q;
   assign csr_count_o    = index;
   assign bus.adc_we_o   = we_q;
   assign bus.adc_addr_o = addr_q;
   assign bus.adc_data_o = data_q;

endmodule
